// File: rtl/test_ram_bist_pkg.sv
// test_ram_bist_pkg
// Shared definitions for the test-RAM BIST sequencer:
//   - FSM state encoding (also exported on the debug state port)
//   - pattern_sel codes
//   - LFSR seed / tap constants and the single-step helper
//   - error counter width
package test_ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam logic [1:0] PAT_ADDR  = 2'd0;
  localparam logic [1:0] PAT_WALK  = 2'd1;
  localparam logic [1:0] PAT_LFSR  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // Galois right-shift form of x^64+x^63+x^61+x^60+1.
  localparam logic [63:0] LFSR_SEED = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  localparam int ERR_W = 16;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/test_ram_pattern_gen.sv
// test_ram_pattern_gen
// Produces one data word of the selected BIST pattern.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (LFSR returns to seed)
//   idx_i       word index within the window
//   addr_i      RAM address of the word
//   sel_i       pattern select (PAT_* codes)
//   step_i      advance the LFSR after this word
//   reseed_i    reload the LFSR with the seed (wins over step_i)
//   data_o      pattern word for (idx_i, addr_i)
module test_ram_pattern_gen #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   idx_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        sel_i,
  input  logic              step_i,
  input  logic              reseed_i,
  output logic [DATA_W-1:0] data_o
);
  import test_ram_bist_pkg::*;

  // Address is zero-extended to a whole number of bytes, then that lane is
  // repeated across the word (10-bit address -> 16-bit lanes).
  localparam int LANE_W = ((ADDR_W + 7) / 8) * 8;
  localparam int AREP   = (DATA_W + LANE_W - 1) / LANE_W;
  localparam int LREP   = (DATA_W + 63) / 64;
  localparam logic [ADDR_W:0] DW_IDX = (ADDR_W + 1)'(DATA_W);

  logic [63:0]            lfsr_q;
  logic [LANE_W-1:0]      addr_lane;
  logic [AREP*LANE_W-1:0] addr_rep;
  logic [LREP*64-1:0]     lfsr_rep;
  logic [ADDR_W:0]        walk_pos;
  logic [DATA_W-1:0]      walk_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (reseed_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign addr_lane = LANE_W'(addr_i);
  assign addr_rep  = {AREP{addr_lane}};
  assign lfsr_rep  = {LREP{lfsr_q}};
  assign walk_pos  = idx_i % DW_IDX;
  assign walk_one  = {{(DATA_W-1){1'b0}}, 1'b1} << walk_pos;

  always_comb begin
    data_o = '0;
    case (sel_i)
      PAT_ADDR: data_o = addr_rep[DATA_W-1:0];
      PAT_WALK: data_o = walk_one;
      PAT_LFSR: data_o = lfsr_rep[DATA_W-1:0];
      default:  data_o = idx_i[0] ? {(DATA_W/8){8'h55}} : {(DATA_W/8){8'hAA}};
    endcase
  end

endmodule

// File: rtl/test_ram_bist.sv
// test_ram_bist
// Fills an address window of the dual-port test RAM with a pattern through
// port A, reads it back through port B and checks it against a regenerated
// copy of the same pattern.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle request (only seen while idle)
//   pattern_sel              0 address, 1 walking-one, 2 LFSR, 3 checkerboard
//   base_addr, length        window, latched on an accepted start
//   wr_addr/wr_data/wr_en/wr_be   RAM port-A write interface
//   rd_addr/rd_en/rd_data    RAM port-B read interface (RD_LAT cycles latency)
//   busy, done, pass         status; done is a one-cycle pulse
//   err_count                saturating mismatch count
//   first_err_addr           address of the first mismatch (0 if none)
//   dbg_state                current FSM state
//
// Handshake: start is a single-cycle request accepted only when busy is low;
// an accepted start raises busy on the next cycle, busy stays high through the
// one-cycle done pulse, and pass/err_count/first_err_addr are valid from done
// until the next accepted start. start while busy has no effect.
module test_ram_bist #(
  parameter int DATA_W = 64,
  parameter int BE_W   = DATA_W / 8,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [1:0]                           pattern_sel,
  input  logic [ADDR_W-1:0]                    base_addr,
  input  logic [ADDR_W:0]                      length,
  output logic [ADDR_W-1:0]                    wr_addr,
  output logic [DATA_W-1:0]                    wr_data,
  output logic                                 wr_en,
  output logic [BE_W-1:0]                      wr_be,
  output logic [ADDR_W-1:0]                    rd_addr,
  output logic                                 rd_en,
  input  logic [DATA_W-1:0]                    rd_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 pass,
  output logic [test_ram_bist_pkg::ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0]                    first_err_addr,
  output logic [2:0]                           dbg_state
);
  import test_ram_bist_pkg::*;

  localparam logic [ADDR_W:0]   IDX_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [7:0]        DRAIN_LAST = 8'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          sel_q, sel_d;
  logic [7:0]          drain_q, drain_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                pass_q, pass_d;

  logic                wr_reseed, exp_reseed;
  logic                last_word;
  logic [DATA_W-1:0]   wr_pat, exp_pat;
  logic                cmp_valid;
  logic [DATA_W-1:0]   cmp_data;
  logic [ADDR_W-1:0]   cmp_addr;
  logic                mismatch;

  // Two generators from the same seed: one paces the writes, the other is
  // reseeded on READ entry and replays the identical stream for checking.
  test_ram_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr_gen (
    .clk      (clk),
    .rst      (rst),
    .idx_i    (idx_q),
    .addr_i   (addr_q),
    .sel_i    (sel_q),
    .step_i   (wr_en),
    .reseed_i (wr_reseed),
    .data_o   (wr_pat)
  );

  test_ram_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_exp_gen (
    .clk      (clk),
    .rst      (rst),
    .idx_i    (idx_q),
    .addr_i   (addr_q),
    .sel_i    (sel_q),
    .step_i   (rd_en),
    .reseed_i (exp_reseed),
    .data_o   (exp_pat)
  );

  // Expected data/address delay line, aligned with rd_data.
  if (RD_LAT == 0) begin : g_no_lat
    assign cmp_valid = rd_en;
    assign cmp_data  = exp_pat;
    assign cmp_addr  = addr_q;
  end else begin : g_lat
    logic [RD_LAT-1:0]        vld_sr;
    logic [RD_LAT*DATA_W-1:0] dat_sr;
    logic [RD_LAT*ADDR_W-1:0] adr_sr;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_sr <= '0;
        dat_sr <= '0;
        adr_sr <= '0;
      end else begin
        vld_sr <= (vld_sr << 1) | RD_LAT'(rd_en);
        dat_sr <= (dat_sr << DATA_W) | (RD_LAT*DATA_W)'(exp_pat);
        adr_sr <= (adr_sr << ADDR_W) | (RD_LAT*ADDR_W)'(addr_q);
      end
    end

    assign cmp_valid = vld_sr[RD_LAT-1];
    assign cmp_data  = dat_sr[RD_LAT*DATA_W-1 -: DATA_W];
    assign cmp_addr  = adr_sr[RD_LAT*ADDR_W-1 -: ADDR_W];
  end

  assign mismatch  = cmp_valid && (rd_data != cmp_data);
  assign last_word = (idx_q + IDX_ONE) == len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      drain_q <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    base_d     = base_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    drain_d    = drain_q;
    err_d      = err_q;
    first_d    = first_q;
    pass_d     = pass_q;
    wr_reseed  = 1'b0;
    exp_reseed = 1'b0;

    if (mismatch) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (err_q == '0) first_d = cmp_addr;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d     = length;
          base_d    = base_addr;
          sel_d     = pattern_sel;
          idx_d     = '0;
          addr_d    = base_addr;
          err_d     = '0;
          first_d   = '0;
          pass_d    = 1'b0;
          wr_reseed = 1'b1;
          state_d   = (length == '0) ? ST_FIN : ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d  = idx_q + IDX_ONE;
        addr_d = addr_q + ADDR_ONE;
        if (last_word) begin
          idx_d      = '0;
          addr_d     = base_q;
          exp_reseed = 1'b1;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        idx_d  = idx_q + IDX_ONE;
        addr_d = addr_q + ADDR_ONE;
        if (last_word) begin
          idx_d   = '0;
          drain_d = '0;
          state_d = (RD_LAT == 0) ? ST_FIN : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 8'd1;
        if (drain_q == DRAIN_LAST) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The last compare lands on the same edge that enters FIN, so pass is
    // derived from the next-state error count.
    if (state_d == ST_FIN && state_q != ST_FIN) pass_d = (err_d == '0);
  end

  assign wr_en          = (state_q == ST_WRITE);
  assign rd_en          = (state_q == ST_READ);
  assign wr_addr        = wr_en ? addr_q : '0;
  assign wr_data        = wr_en ? wr_pat : '0;
  assign wr_be          = {BE_W{wr_en}};
  assign rd_addr        = rd_en ? addr_q : '0;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_FIN);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign dbg_state      = state_q;

endmodule
